// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with saturating direction counters.
// Optional hit/misprediction statistics are compiled in with BTB_STATS_EN.
module branch_target_buffer #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lookup_en,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            flush,
    output logic [31:0]     stat_hits,
    output logic [31:0]     stat_mispred
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [XLEN-1:0]    targets [ENTRIES];
    logic [CTR_W-1:0]   ctrs    [ENTRIES];

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             u_hit, u_pred_taken, mispred;
    logic [CTR_W-1:0] u_ctr, ctr_next;

    always_comb begin
        l_idx        = lookup_pc[IDX_W+1:2];
        l_tag        = lookup_pc[XLEN-1:IDX_W+2];
        u_idx        = upd_pc[IDX_W+1:2];
        u_tag        = upd_pc[XLEN-1:IDX_W+2];
        pred_hit     = valid[l_idx] && tags[l_idx] == l_tag;
        pred_taken   = pred_hit && ctrs[l_idx][CTR_W-1];
        pred_target  = pred_hit ? targets[l_idx] : '0;
        u_hit        = valid[u_idx] && tags[u_idx] == u_tag;
        u_ctr        = ctrs[u_idx];
        u_pred_taken = u_hit && u_ctr[CTR_W-1];
        mispred      = (u_pred_taken != upd_taken) ||
                       (u_pred_taken && upd_taken && targets[u_idx] != upd_target);
        ctr_next     = upd_taken ? (u_ctr == CTR_MAX ? u_ctr : u_ctr + CTR_W'(1))
                                 : (u_ctr == '0 ? u_ctr : u_ctr - CTR_W'(1));
    end

    // Flush only drops valid bits; a coincident update is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tags[i]    <= '0;
                targets[i] <= '0;
                ctrs[i]    <= '0;
            end
        end else if (flush) begin
            valid <= '0;
        end else if (upd_valid) begin
            if (u_hit) begin
                ctrs[u_idx] <= ctr_next;
                if (upd_taken)
                    targets[u_idx] <= upd_target;
            end else if (upd_taken) begin
                valid[u_idx]   <= 1'b1;
                tags[u_idx]    <= u_tag;
                targets[u_idx] <= upd_target;
                ctrs[u_idx]    <= CTR_WEAK;
            end
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

`ifdef BTB_STATS_EN
    logic [31:0] hits, mispreds;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits     <= '0;
            mispreds <= '0;
        end else begin
            if (lookup_en && pred_hit && hits != '1)
                hits <= hits + 32'd1;
            if (upd_valid && !flush && mispred && mispreds != '1)
                mispreds <= mispreds + 32'd1;
        end
    end

    assign stat_hits    = hits;
    assign stat_mispred = mispreds;
`else
    logic unused_stats;
    assign unused_stats = lookup_en ^ mispred;
    assign stat_hits    = '0;
    assign stat_mispred = '0;
`endif
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed vector table plus hand sequences for the BTB.
module tb_branch_target_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lookup_en = 1'b0;
    logic [31:0] lookup_pc = 32'h100;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        flush = 1'b0;
    logic [31:0] stat_hits, stat_mispred;

    int checks = 0;
    int errors = 0;

    branch_target_buffer dut (
        .clk(clk), .rst_n(rst_n), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .flush(flush),
        .stat_hits(stat_hits), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic        fl;
        logic [31:0] lpc;
        logic        eh;
        logic        et;
        logic [31:0] etg;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_hits, exp_mp;
`ifdef BTB_STATS_EN
        exp_hits = 32'd5;
        exp_mp   = 32'd9;
`else
        exp_hits = 32'd0;
        exp_mp   = 32'd0;
`endif
        //          uv    upc       ut    utg       fl    lpc       eh    et    etg
        vecs[0]  = '{1'b1, 32'h100, 1'b1, 32'h080, 1'b0, 32'h100, 1'b1, 1'b1, 32'h080};
        vecs[1]  = '{1'b1, 32'h100, 1'b0, 32'h000, 1'b0, 32'h100, 1'b1, 1'b0, 32'h080};
        vecs[2]  = '{1'b1, 32'h100, 1'b0, 32'h000, 1'b0, 32'h100, 1'b1, 1'b0, 32'h080};
        vecs[3]  = '{1'b1, 32'h100, 1'b0, 32'h000, 1'b0, 32'h100, 1'b1, 1'b0, 32'h080};
        vecs[4]  = '{1'b1, 32'h100, 1'b1, 32'h080, 1'b0, 32'h100, 1'b1, 1'b0, 32'h080};
        vecs[5]  = '{1'b1, 32'h100, 1'b1, 32'h080, 1'b0, 32'h100, 1'b1, 1'b1, 32'h080};
        vecs[6]  = '{1'b1, 32'h100, 1'b1, 32'h080, 1'b0, 32'h100, 1'b1, 1'b1, 32'h080};
        vecs[7]  = '{1'b1, 32'h100, 1'b1, 32'h090, 1'b0, 32'h100, 1'b1, 1'b1, 32'h090};
        vecs[8]  = '{1'b1, 32'h100, 1'b0, 32'h000, 1'b0, 32'h100, 1'b1, 1'b1, 32'h090};
        vecs[9]  = '{1'b1, 32'h100, 1'b0, 32'h123, 1'b0, 32'h100, 1'b1, 1'b0, 32'h090};
        vecs[10] = '{1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 32'h100, 1'b0, 1'b0, 32'h000};
        vecs[11] = '{1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h140, 1'b1, 1'b1, 32'h200};
        vecs[12] = '{1'b1, 32'h144, 1'b0, 32'h444, 1'b0, 32'h144, 1'b0, 1'b0, 32'h000};
        vecs[13] = '{1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h142, 1'b1, 1'b1, 32'h200};
        vecs[14] = '{1'b1, 32'h180, 1'b1, 32'h300, 1'b1, 32'h140, 1'b0, 1'b0, 32'h000};
        vecs[15] = '{1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h180, 1'b0, 1'b0, 32'h000};

        #1;
        chk("reset_hit", {31'd0, pred_hit}, 32'd0);
        chk("reset_target", pred_target, 32'd0);
        chk("reset_hits", stat_hits, 32'd0);
        chk("reset_mispred", stat_mispred, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            upd_valid  = vecs[i].uv;
            upd_pc     = vecs[i].upc;
            upd_taken  = vecs[i].ut;
            upd_target = vecs[i].utg;
            flush      = vecs[i].fl;
            lookup_pc  = vecs[i].lpc;
            @(posedge clk);
            #1;
            upd_valid = 1'b0;
            flush     = 1'b0;
            chk($sformatf("v%0d_hit", i), {31'd0, pred_hit}, {31'd0, vecs[i].eh});
            chk($sformatf("v%0d_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].et});
            chk($sformatf("v%0d_target", i), pred_target, vecs[i].etg);
        end

        // Same-cycle lookup sees the table before the update commits.
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = 32'h1C0;
        upd_taken  = 1'b1;
        upd_target = 32'h400;
        lookup_pc  = 32'h1C0;
        #1;
        chk("bypass_pre_hit", {31'd0, pred_hit}, 32'd0);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        chk("bypass_post_hit", {31'd0, pred_hit}, 32'd1);
        chk("bypass_post_target", pred_target, 32'h400);

        // Five qualified hit cycles.
        @(negedge clk);
        lookup_en = 1'b1;
        repeat (5) @(negedge clk);
        lookup_en = 1'b0;
        chk("stat_hits", stat_hits, exp_hits);
        chk("stat_mispred", stat_mispred, exp_mp);
        @(negedge clk);
        chk("stat_hits_idle", stat_hits, exp_hits);

        // Reset coincident with an update discards it; first post-reset edge accepts.
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = 32'h200;
        upd_taken  = 1'b1;
        upd_target = 32'h500;
        lookup_pc  = 32'h1C0;
        rst_n      = 1'b0;
        #1;
        chk("async_rst_hit", {31'd0, pred_hit}, 32'd0);
        chk("async_rst_target", pred_target, 32'd0);
        chk("async_rst_hits", stat_hits, 32'd0);
        chk("async_rst_mispred", stat_mispred, 32'd0);
        lookup_pc = 32'h200;
        @(posedge clk);
        #1;
        chk("rst_upd_dropped", {31'd0, pred_hit}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        chk("post_rst_hit", {31'd0, pred_hit}, 32'd1);
        chk("post_rst_target", pred_target, 32'h500);
        chk("post_rst_taken", {31'd0, pred_taken}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/target width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16, table depth; power of 2, 4..256.
REQ-003 SHALL have parameter CTR_W, default 2, saturating-counter width, 1..4.
REQ-004 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-005 SHALL have port RST_N  in  1  asynchronous active-low reset.
REQ-006 SHALL have port LOOKUP_EN  in  1  lookup qualifier; gates statistics only.
REQ-007 SHALL have port LOOKUP_PC  in  XLEN  fetch PC to predict.
REQ-008 SHALL have port PRED_HIT  out  1  valid entry with matching tag for LOOKUP_PC.
REQ-009 SHALL have port PRED_TAKEN  out  1  predict taken: PRED_HIT and counter MSB set.
REQ-010 SHALL have port PRED_TARGET  out  XLEN  stored target; 0 when PRED_HIT=0.
REQ-011 SHALL have port UPD_VALID  in  1  resolved-branch update strobe, one cycle.
REQ-012 SHALL have port UPD_PC  in  XLEN  PC of resolved branch.
REQ-013 SHALL have port UPD_TAKEN  in  1  actual branch outcome.
REQ-014 SHALL have port UPD_TARGET  in  XLEN  actual branch target.
REQ-015 SHALL have port FLUSH  in  1  invalidate all entries.
REQ-016 SHALL have port STAT_HITS  out  32  lookup hit count.
REQ-017 SHALL have port STAT_MISPRED  out  32  misprediction count.

Function
REQ-018 SHALL be direct-mapped: index = PC[IDX_W+1:2], tag = PC[XLEN-1:IDX_W+2], IDX_W = log2(ENTRIES); PC[1:0] ignored.
REQ-019 SHALL hold per entry: valid bit, tag, XLEN target, CTR_W counter.
REQ-020 SHALL produce PRED_HIT/PRED_TAKEN/PRED_TARGET combinationally from LOOKUP_PC and current table state (zero-cycle latency).
REQ-021 SHALL, on UPD_VALID with tag hit: counter +1 saturating at all-ones if UPD_TAKEN, -1 saturating at 0 otherwise; target overwritten with UPD_TARGET only when UPD_TAKEN.
REQ-022 SHALL, on UPD_VALID with miss and UPD_TAKEN=1: allocate/replace the entry, valid=1, new tag, target=UPD_TARGET, counter=2^(CTR_W-1) (weakly taken).
REQ-023 SHALL, on UPD_VALID with miss and UPD_TAKEN=0: leave the table unchanged.
REQ-024 SHALL commit updates at the rising edge ending the UPD_VALID cycle; a same-cycle lookup of the same index SHALL see pre-update state.
REQ-025 SHALL, on FLUSH, clear all valid bits at the next edge; FLUSH SHALL override a coincident UPD_VALID (update dropped); targets/counters retained.
REQ-026 SHALL define a misprediction at UPD_VALID as: table prediction for UPD_PC (hit and MSB) differs from UPD_TAKEN, or predicted taken and UPD_TAKEN=1 with stored target != UPD_TARGET.

Reset
REQ-027 SHALL, while RST_N=0, asynchronously clear all valid bits, counters, targets, tags and both statistics counters to 0.
REQ-028 SHALL therefore drive PRED_HIT=0, PRED_TAKEN=0, PRED_TARGET=0, STAT_HITS=0, STAT_MISPRED=0 during and after reset.
REQ-029 SHALL discard any update coincident with reset assertion; first update accepted on first edge after RST_N deasserts.

Configuration
REQ-030 SHALL compile statistics only when macro BTB_STATS_EN is defined.
REQ-031 SHALL, with BTB_STATS_EN: increment STAT_HITS on each edge with LOOKUP_EN=1 and PRED_HIT=1; increment STAT_MISPRED on each accepted UPD_VALID meeting REQ-026; both saturate at 32'hFFFF_FFFF; FLUSH does not clear them.
REQ-032 SHALL, without BTB_STATS_EN: keep both ports, tie to constant 0, instantiate no counter flops.

Verification
REQ-033 Reset, LOOKUP_PC=0x100 -> PRED_HIT=0, PRED_TARGET=0, stats 0.
REQ-034 UPD 0x100 taken target 0x80, then lookup 0x100 -> HIT=1, TAKEN=1, TARGET=0x80; counter=2'b10; STAT_MISPRED=1.
REQ-035 Same branch not-taken twice -> counter 10->01->00, PRED_TAKEN=0 after first; taken x3 -> saturates at 11.
REQ-036 ENTRIES=16: UPD 0x100 taken then UPD 0x140 taken (same index, different tag) -> lookup 0x100 misses, 0x140 hits.
REQ-037 FLUSH and UPD_VALID same cycle -> next cycle all lookups miss; update absent.
REQ-038 BTB_STATS_EN, STAT_HITS preset near 32'hFFFF_FFFF via repeated hits -> holds at 32'hFFFF_FFFF; without macro -> stays 0.
